// File: rtl/mem_access.sv
// Data-memory access stage: converts EX/MEM load/store controls into a req/ack RAM transaction.
// Optional macro MEM_ALIGN_CHECK_EN enables misaligned half/word detection.
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        EX_MEM_MemRead,
    input  logic        EX_MEM_MemWrite,
    input  logic [1:0]  EX_MEM_size,
    input  logic        EX_MEM_unsigned,
    input  logic        EX_MEM_RegWrite,
    input  logic [31:0] EX_MEM_aluout,
    input  logic [31:0] EX_MEM_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        RegWrite_o,
    output logic [31:0] dout,
    output logic        misalign
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state_reg, state_next;
    logic        mem_op, misaligned, start, stall_next, misalign_next;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic        mem_req_reg, mem_we_reg, unsigned_reg;
    logic [1:0]  lane_reg, size_reg;
    logic [3:0]  mem_be_reg;
    logic [31:0] mem_addr_reg, mem_wdata_reg, dout_reg;
    logic [7:0]  rdata_byte [4];
    logic [15:0] rdata_half;
    logic [31:0] load_ext;

    assign mem_op = EX_MEM_MemRead | EX_MEM_MemWrite;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = ((EX_MEM_size == 2'b01) && EX_MEM_aluout[0]) ||
                        (EX_MEM_size[1] && (EX_MEM_aluout[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        be_next    = 4'b1111;
        wdata_next = EX_MEM_wdata;
        case (EX_MEM_size)
            2'b00: begin
                be_next    = 4'b0001 << EX_MEM_aluout[1:0];
                wdata_next = {4{EX_MEM_wdata[7:0]}};
            end
            2'b01: begin
                be_next    = EX_MEM_aluout[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{EX_MEM_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane selection uses the address bits captured at request time.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rdata_byte[gi] = mem_rdata[8*gi +: 8];
        end
    endgenerate

    assign rdata_half = lane_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_ext = mem_rdata;
        case (size_reg)
            2'b00:   load_ext = {{24{~unsigned_reg & rdata_byte[lane_reg][7]}}, rdata_byte[lane_reg]};
            2'b01:   load_ext = {{16{~unsigned_reg & rdata_half[15]}}, rdata_half};
            default: ;
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        stall_next    = 1'b0;
        misalign_next = 1'b0;
        start         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (mem_op) begin
                    if (misaligned) begin
                        misalign_next = 1'b1;
                    end else begin
                        start      = 1'b1;
                        stall_next = 1'b1;
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                stall_next = 1'b1;
                if (mem_ack) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= 32'd0;
            mem_be_reg    <= 4'd0;
            mem_wdata_reg <= 32'd0;
            dout_reg      <= 32'd0;
            lane_reg      <= 2'd0;
            size_reg      <= 2'd0;
            unsigned_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            mem_req_reg <= (state_next == REQ);
            if (start) begin
                mem_we_reg    <= EX_MEM_MemWrite;
                mem_addr_reg  <= {EX_MEM_aluout[31:2], 2'b00};
                mem_be_reg    <= be_next;
                mem_wdata_reg <= wdata_next;
                lane_reg      <= EX_MEM_aluout[1:0];
                size_reg      <= EX_MEM_size;
                unsigned_reg  <= EX_MEM_unsigned;
            end
            // A combined read+write request is a write, so dout is left alone.
            if ((state_reg == REQ) && mem_ack && !mem_we_reg)
                dout_reg <= load_ext;
        end
    end

    assign mem_req    = mem_req_reg;
    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_be     = mem_be_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign dout       = dout_reg;
    assign stall      = stall_next;
    assign misalign   = misalign_next;
    assign RegWrite_o = EX_MEM_RegWrite & ~stall_next & ~misalign_next;
endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access; expected load results are queued at issue and popped in DONE.
module tb_mem_access;
    logic        clk = 1'b0;
    logic        rst;
    logic        EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_unsigned, EX_MEM_RegWrite;
    logic [1:0]  EX_MEM_size;
    logic [31:0] EX_MEM_aluout, EX_MEM_wdata;
    logic        mem_req, mem_we, mem_ack, stall, RegWrite_o, misalign;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, dout;
    logic [3:0]  mem_be;

    int          total = 0;
    int          bad = 0;
    logic [31:0] sb_q [$];

    always #5 clk = ~clk;

    mem_access dut (
        .clk(clk), .rst(rst),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
        .EX_MEM_size(EX_MEM_size), .EX_MEM_unsigned(EX_MEM_unsigned),
        .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_aluout(EX_MEM_aluout),
        .EX_MEM_wdata(EX_MEM_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall(stall), .RegWrite_o(RegWrite_o), .dout(dout), .misalign(misalign)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_nop();
        EX_MEM_MemRead  = 1'b0;
        EX_MEM_MemWrite = 1'b0;
        EX_MEM_size     = 2'b10;
        EX_MEM_unsigned = 1'b0;
        EX_MEM_RegWrite = 1'b0;
        EX_MEM_aluout   = 32'd0;
        EX_MEM_wdata    = 32'd0;
    endtask

    // Called just after a rising edge; returns just after the edge that leaves DONE.
    task automatic mem_op(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic rw, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rdata, input int n,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_dout);
        int          stall_cycles;
        logic [31:0] exp_q;
        stall_cycles    = 0;
        EX_MEM_MemRead  = rd;
        EX_MEM_MemWrite = wr;
        EX_MEM_size     = sz;
        EX_MEM_unsigned = uns;
        EX_MEM_RegWrite = rw;
        EX_MEM_aluout   = addr;
        EX_MEM_wdata    = wd;
        sb_q.push_back(exp_dout);
        @(negedge clk);
        check({tag, "_idle_req"}, {31'd0, mem_req}, 32'd0);
        check({tag, "_idle_rw"}, {31'd0, RegWrite_o}, 32'd0);
        if (stall) stall_cycles++;
        @(posedge clk); #1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            check({tag, "_req"}, {31'd0, mem_req}, 32'd1);
            check({tag, "_addr"}, mem_addr, exp_addr);
            check({tag, "_be"}, {28'd0, mem_be}, {28'd0, exp_be});
            check({tag, "_wdata"}, mem_wdata, exp_wdata);
            check({tag, "_we"}, {31'd0, mem_we}, {31'd0, wr});
            check({tag, "_req_rw"}, {31'd0, RegWrite_o}, 32'd0);
            if (stall) stall_cycles++;
            if (i == n) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end
            @(posedge clk); #1;
            mem_ack   = 1'b0;
            mem_rdata = 32'h5A5A_C3C3;
        end
        @(negedge clk);
        check({tag, "_done_stall"}, {31'd0, stall}, 32'd0);
        check({tag, "_done_req"}, {31'd0, mem_req}, 32'd0);
        check({tag, "_done_rw"}, {31'd0, RegWrite_o}, {31'd0, rw});
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end else begin
            exp_q = sb_q.pop_front();
            check({tag, "_dout"}, dout, exp_q);
        end
        check({tag, "_stall_cycles"}, stall_cycles, n + 1);
        @(posedge clk); #1;
    endtask

    initial begin
        rst       = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        drive_nop();
        #3;
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_be", {28'd0, mem_be}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_dout", dout, 32'd0);
        check("rst_misalign", {31'd0, misalign}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Non-memory instruction with a stray ack: passes through unstalled.
        EX_MEM_RegWrite = 1'b1;
        mem_ack         = 1'b1;
        @(negedge clk);
        check("nop_stall", {31'd0, stall}, 32'd0);
        check("nop_rw", {31'd0, RegWrite_o}, 32'd1);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("nop_ack_ignored", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;

        mem_op("lw", 1, 0, 2'b10, 0, 1, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 2,
               32'h0000_0010, 4'b1111, 32'd0, 32'hDEAD_BEEF);
        mem_op("sb", 0, 1, 2'b00, 0, 0, 32'h0000_0023, 32'h0000_00A5, 32'h1111_1111, 1,
               32'h0000_0020, 4'b1000, 32'hA5A5_A5A5, 32'hDEAD_BEEF);
        mem_op("lh", 1, 0, 2'b01, 0, 1, 32'h0000_0042, 32'd0, 32'h8001_1234, 1,
               32'h0000_0040, 4'b1100, 32'd0, 32'hFFFF_8001);
        mem_op("lhu", 1, 0, 2'b01, 1, 1, 32'h0000_0042, 32'd0, 32'h8001_1234, 3,
               32'h0000_0040, 4'b1100, 32'd0, 32'h0000_8001);
        mem_op("lb", 1, 0, 2'b00, 0, 1, 32'h0000_0101, 32'd0, 32'h0000_F700, 1,
               32'h0000_0100, 4'b0010, 32'd0, 32'hFFFF_FFF7);
        mem_op("lbu", 1, 0, 2'b00, 1, 1, 32'h0000_0101, 32'd0, 32'h0000_F700, 2,
               32'h0000_0100, 4'b0010, 32'd0, 32'h0000_00F7);
        mem_op("sh", 0, 1, 2'b01, 0, 0, 32'h0000_0052, 32'h1234_BEEF, 32'h2222_2222, 1,
               32'h0000_0050, 4'b1100, 32'hBEEF_BEEF, 32'h0000_00F7);
        mem_op("rdwr", 1, 1, 2'b11, 0, 0, 32'h0000_0060, 32'h1122_3344, 32'h3333_3333, 1,
               32'h0000_0060, 4'b1111, 32'h1122_3344, 32'h0000_00F7);

`ifdef MEM_ALIGN_CHECK_EN
        EX_MEM_MemRead  = 1'b1;
        EX_MEM_size     = 2'b10;
        EX_MEM_RegWrite = 1'b1;
        EX_MEM_aluout   = 32'h0000_0041;
        @(negedge clk);
        check("mis_flag", {31'd0, misalign}, 32'd1);
        check("mis_stall", {31'd0, stall}, 32'd0);
        check("mis_rw", {31'd0, RegWrite_o}, 32'd0);
        check("mis_req", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
        drive_nop();
        @(negedge clk);
        check("mis_req_after", {31'd0, mem_req}, 32'd0);
        check("mis_flag_after", {31'd0, misalign}, 32'd0);
        check("mis_dout", dout, 32'h0000_00F7);
        @(posedge clk); #1;
`else
        mem_op("lw_unal", 1, 0, 2'b10, 0, 1, 32'h0000_0041, 32'd0, 32'hCAFE_F00D, 1,
               32'h0000_0040, 4'b1111, 32'd0, 32'hCAFE_F00D);
        check("unal_misalign", {31'd0, misalign}, 32'd0);
`endif

        // Reset during the second REQ cycle.
        EX_MEM_MemRead  = 1'b1;
        EX_MEM_size     = 2'b10;
        EX_MEM_RegWrite = 1'b1;
        EX_MEM_aluout   = 32'h0000_0080;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_req_before", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_req", {31'd0, mem_req}, 32'd0);
        check("mid_rst_dout", dout, 32'd0);
        check("mid_rst_addr", mem_addr, 32'd0);
        drive_nop();
        #1;
        check("mid_rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        mem_op("lw_after_rst", 1, 0, 2'b10, 0, 1, 32'h0000_0090, 32'd0, 32'h0BAD_F00D, 2,
               32'h0000_0090, 4'b1111, 32'd0, 32'h0BAD_F00D);

        drive_nop();
        @(negedge clk);
        check("final_idle_req", {31'd0, mem_req}, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_access.md
# mem_access

Data-memory access stage of the five-stage pipelined CPU. It sits between the EX/MEM and MEM/WB pipeline registers. It turns the EX/MEM load/store controls into a registered request/acknowledge transaction to the data RAM, generates byte enables and store-data lane replication, and sign- or zero-extends load data. While a transaction is outstanding it stalls the upstream pipeline and feeds a write-disabled bubble into MEM/WB.

## Interface
- No parameters; address and data paths are fixed at 32 bits.
- `clk` in 1: pipeline clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `EX_MEM_MemRead` in 1: load in MEM stage.
- `EX_MEM_MemWrite` in 1: store in MEM stage.
- `EX_MEM_size` in 2: access size; 00 = byte, 01 = half, 10 or 11 = word.
- `EX_MEM_unsigned` in 1: zero-extend loads when 1, sign-extend when 0.
- `EX_MEM_RegWrite` in 1: register-write control from EX/MEM.
- `EX_MEM_aluout` in 32: byte address.
- `EX_MEM_wdata` in 32: store data, right-justified.
- `mem_req` out 1: request to data RAM; registered.
- `mem_we` out 1: 1 = write.
- `mem_addr` out 32: word-aligned address.
- `mem_be` out 4: byte enables; bit i = byte lane i.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ack` in 1: RAM completion; sampled on the rising edge.
- `mem_rdata` in 32: RAM read word; valid in the `mem_ack` cycle.
- `stall` out 1: freezes PC, IF/ID, ID/EX and EX/MEM.
- `RegWrite_o` out 1: to MEM/WB; `EX_MEM_RegWrite & ~stall`, and also 0 on a misaligned access.
- `dout` out 32: extended load data to MEM/WB.
- `misalign` out 1: misaligned-access flag to the exception logic.

## Operation
- FSM states:
  - IDLE: if `EX_MEM_MemRead | EX_MEM_MemWrite` and the access is not misaligned: assert `stall`, latch `mem_addr`, `mem_be`, `mem_wdata` and `mem_we`, and go to REQ. Otherwise `stall`=0.
  - REQ: `mem_req`=1 and `stall`=1. On `mem_ack`, latch the extended `mem_rdata` into `dout` and go to DONE. Otherwise stay in REQ.
  - DONE: `stall`=0, so MEM/WB captures `dout` and EX/MEM advances at the next edge. Go to IDLE unconditionally.
- Read/write priority: if `EX_MEM_MemRead` and `EX_MEM_MemWrite` are both 1, the access is a write; the read is ignored and `dout` is unchanged.
- `mem_ack` is ignored in IDLE and DONE.
- Address: `mem_addr` = {`EX_MEM_aluout[31:2]`, 2'b00}.
- Byte access: `mem_be` = 1 << addr[1:0]; `mem_wdata` = wdata[7:0] replicated into all 4 lanes.
- Half access: `mem_be` = addr[1] ? 1100 : 0011; `mem_wdata` = wdata[15:0] replicated into both halves.
- Word access: `mem_be` = 1111; `mem_wdata` = wdata.
- Load extraction: select the lane from `mem_rdata` by addr[1:0] (byte) or addr[1] (half), then extend to 32 bits per `EX_MEM_unsigned`. Word loads ignore `EX_MEM_unsigned`.
- `dout` holds its last value outside load completion; stores do not change it.

## Timing
- Memory operation latency: 1 cycle in IDLE, then N≥1 cycles in REQ (ack in the N-th), then 1 cycle in DONE.
- Minimum 3 cycles per memory operation; `stall` is high for N+1 cycles.
- Non-memory instructions take 1 cycle with `stall`=0; MEM/WB sees them unchanged.
- Back-to-back memory operations: DONE → IDLE → a new request; there is no idle gap beyond the IDLE cycle.
- `mem_req`, `mem_we`, `mem_addr`, `mem_be` and `mem_wdata` stay stable for the whole REQ period.
- Reset values: state IDLE, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_be`=0, `mem_wdata`=0, `dout`=0, `misalign`=0.
  - `stall` and `RegWrite_o` then follow their combinational equations.
- Reset mid-transaction: `rst` drops `mem_req` immediately. An abandoned RAM transaction is the RAM's responsibility.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]≠00, is misaligned.
  - In IDLE it asserts `misalign`=1 for that cycle and forces `RegWrite_o`=0.
  - No request is issued, the FSM stays in IDLE, `stall`=0 and `dout` is unchanged.
- `MEM_ALIGN_CHECK_EN` undefined:
  - `misalign` is tied to 0.
  - Half accesses ignore addr[0]; word accesses ignore addr[1:0].
  - All accesses proceed normally.

## Test plan
- `lw` at 0x0000_0010; `mem_ack` returned 2 cycles into REQ with rdata 0xDEAD_BEEF:
  - `stall` high for 3 cycles, `mem_be`=1111, `mem_addr`=0x10.
  - `dout`=0xDEAD_BEEF in DONE, `RegWrite_o`=1 only in DONE.
- `sb` with wdata 0x0000_00A5 at 0x0000_0023:
  - `mem_addr`=0x20, `mem_be`=1000, `mem_wdata`=0xA5A5_A5A5, `mem_we`=1.
  - `dout` unchanged.
- `lh` (signed) at 0x0000_0042 with rdata 0x8001_1234 → `dout`=0xFFFF_8001. The same access as `lhu` → 0x0000_8001.
- `lb` at 0x…01 with rdata 0x0000_F700 → 0xFFFF_FFF7; `lbu` → 0x0000_00F7.
- With `MEM_ALIGN_CHECK_EN` defined, `lw` at 0x0000_0041:
  - `misalign`=1 for 1 cycle, `mem_req` never asserted, `stall`=0, `RegWrite_o`=0.
- With `MEM_ALIGN_CHECK_EN` undefined, the same access reads word 0x40 normally.
- Assert `rst` in the second REQ cycle:
  - `mem_req` goes to 0 asynchronously, the FSM returns to IDLE and `dout`=0.
  - A following `lw` completes normally.
